gray_step_tracker: RTL and testbench

Downstream consumer of the 4-bit Gray-code stage. Samples each valid Gray code, decodes it back to binary and classifies the move as a single step up, a single step down, or an illegal jump. Legal steps maintain a position accumulator and are queued as step events in a small FIFO, which drains through a valid/ready handshake. Illegal jumps raise a sticky fault that software clears.

---
 rtl/gray_step_tracker.sv | 179 +++++++++++++++++
 tb/tb_gray_step_tracker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_tracker.sv
`timescale 1ns/1ps
// gray_step_tracker
//   Samples 4-bit Gray codes, decodes them to binary and classifies each move
//   against the previous sample as +1, -1 or an illegal jump. Legal steps
//   update a position accumulator and are queued as step events in a
//   show-ahead FIFO drained by a valid/ready handshake. Illegal jumps set a
//   sticky fault that stays until clr_fault, after which tracking reseeds.
//
//   Optional build macro: POS_SAT_EN -- position saturates at 0 and
//   2^POS_W-1 instead of wrapping (events still pushed with clamped value).
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   gray_in/gray_valid  Gray code sample and its qualifier
//   clr_fault           one-cycle pulse, leaves FAULT and reseeds
//   pos                 current position accumulator
//   out_data/out_dir    FIFO head: position after the step, 0 = up, 1 = down
//   out_valid/out_ready FIFO handshake, pop on out_valid & out_ready
//   fault               sticky illegal-jump flag
//   drop_cnt            events lost to a full FIFO, saturating at 255
module gray_step_tracker #(
  parameter int POS_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       gray_in,
  input  logic             gray_valid,
  input  logic             clr_fault,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] out_data,
  output logic             out_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fault,
  output logic [7:0]       drop_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_SEED, ST_TRACK, ST_FAULT} state_t;

  state_t             r_state;
  logic [3:0]         r_prev_bin;
  logic [POS_W-1:0]   r_pos;
  logic               r_fault;
  logic [7:0]         r_drop_cnt;
  logic [POS_W:0]     r_mem [FIFO_DEPTH];   // {dir, position}
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  state_t             w_state_nxt;
  logic [3:0]         w_prev_nxt;
  logic [POS_W-1:0]   w_pos_nxt;
  logic               w_fault_nxt;
  logic               w_push;
  logic               w_push_dir;
  logic [3:0]         w_bin;
  logic [3:0]         w_delta;
  logic [POS_W-1:0]   w_pos_up;
  logic [POS_W-1:0]   w_pos_dn;
  logic               w_full;
  logic               w_pop;
  logic               w_wr_en;
  logic               w_drop;
  logic [POS_W:0]     w_head;

  // Each binary bit is the XOR of all Gray bits at or above it.
  assign w_bin   = {gray_in[3], ^gray_in[3:2], ^gray_in[3:1], ^gray_in[3:0]};
  assign w_delta = w_bin - r_prev_bin;

`ifdef POS_SAT_EN
  assign w_pos_up = (r_pos == {POS_W{1'b1}}) ? r_pos : r_pos + POS_W'(1);
  assign w_pos_dn = (r_pos == '0)            ? r_pos : r_pos - POS_W'(1);
`else
  assign w_pos_up = r_pos + POS_W'(1);
  assign w_pos_dn = r_pos - POS_W'(1);
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev_bin;
    w_pos_nxt   = r_pos;
    w_fault_nxt = r_fault;
    w_push      = 1'b0;
    w_push_dir  = 1'b0;
    case (r_state)
      ST_SEED: begin
        if (gray_valid) begin
          w_prev_nxt  = w_bin;
          w_state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (gray_valid) begin
          case (w_delta)
            4'd0: w_prev_nxt = w_bin;
            4'd1: begin
              w_prev_nxt = w_bin;
              w_pos_nxt  = w_pos_up;
              w_push     = 1'b1;
            end
            4'd15: begin
              w_prev_nxt = w_bin;
              w_pos_nxt  = w_pos_dn;
              w_push     = 1'b1;
              w_push_dir = 1'b1;
            end
            default: begin
              w_fault_nxt = 1'b1;
              w_state_nxt = ST_FAULT;
            end
          endcase
        end
      end
      ST_FAULT: begin
        // Samples are ignored here, even when they coincide with clr_fault.
        if (clr_fault) begin
          w_fault_nxt = 1'b0;
          w_state_nxt = ST_SEED;
        end
      end
      default: w_state_nxt = ST_SEED;
    endcase
  end

  // A pop needs a visible head, so a pop request on an empty FIFO is inert
  // and a simultaneous push still lands. Push-and-pop while full frees the
  // slot the push needs.
  assign out_valid = (r_count != '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = out_valid & out_ready;
  assign w_wr_en   = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_SEED;
      r_prev_bin <= '0;
      r_pos      <= '0;
      r_fault    <= 1'b0;
      r_drop_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev_bin <= w_prev_nxt;
      r_pos      <= w_pos_nxt;
      r_fault    <= w_fault_nxt;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy lives in the
  // pointers/count and the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {w_push_dir, w_pos_nxt};
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign out_data = out_valid ? w_head[POS_W-1:0] : '0;
  assign out_dir  = out_valid & w_head[POS_W];
  assign pos      = r_pos;
  assign fault    = r_fault;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_gray_step_tracker.sv
`timescale 1ns/1ps
// Self-checking bench for gray_step_tracker. A behavioural model evaluated
// mid-cycle predicts each edge's effect; predicted step events go into a
// scoreboard queue and are compared against the FIFO head when popped.
module tb_gray_step_tracker;

  localparam int POS_W = 16;
  localparam int DEPTH = 4;
  localparam int M_SEED = 0, M_TRACK = 1, M_FAULT = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       gray_in = '0;
  logic             gray_valid = 1'b0;
  logic             clr_fault = 1'b0;
  logic             out_ready = 1'b0;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] out_data;
  logic             out_dir;
  logic             out_valid;
  logic             fault;
  logic [7:0]       drop_cnt;

  gray_step_tracker #(.POS_W(POS_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .gray_valid(gray_valid),
    .clr_fault(clr_fault), .pos(pos), .out_data(out_data), .out_dir(out_dir),
    .out_valid(out_valid), .out_ready(out_ready), .fault(fault),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Reference model state
  logic [POS_W:0]   sb[$];           // {dir, pos}
  int               m_state = M_SEED;
  logic [3:0]       m_prev  = '0;
  logic [POS_W-1:0] m_pos   = '0;
  logic             m_fault = 1'b0;
  logic [7:0]       m_drop  = '0;

  always @(negedge clk) begin : monitor
    int         sz;
    bit         pop, push, dir;
    logic [3:0] b, d;
    if (chk_en) begin
      sz = sb.size();
      check("out_valid", 32'(out_valid), 32'(sz != 0));
      check("pos", 32'(pos), 32'(m_pos));
      check("fault", 32'(fault), 32'(m_fault));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (sz != 0) begin
        check("out_data", 32'(out_data), 32'(sb[0][POS_W-1:0]));
        check("out_dir", 32'(out_dir), 32'(sb[0][POS_W]));
      end
      pop = out_ready && (sz != 0);
      if (pop) begin
        void'(sb.pop_front());
        n_pop++;
      end
      if (!rst_n) begin
        sb.delete();
        m_state = M_SEED; m_prev = '0; m_pos = '0; m_fault = 1'b0; m_drop = '0;
      end else begin
        push = 1'b0; dir = 1'b0;
        b = g2b(gray_in);
        if (m_state == M_SEED) begin
          if (gray_valid) begin m_prev = b; m_state = M_TRACK; end
        end else if (m_state == M_TRACK) begin
          if (gray_valid) begin
            d = b - m_prev;
            if (d == 4'd1) begin
              push = 1'b1;
`ifdef POS_SAT_EN
              if (m_pos != {POS_W{1'b1}}) m_pos = m_pos + 1'b1;
`else
              m_pos = m_pos + 1'b1;
`endif
            end else if (d == 4'd15) begin
              push = 1'b1; dir = 1'b1;
`ifdef POS_SAT_EN
              if (m_pos != '0) m_pos = m_pos - 1'b1;
`else
              m_pos = m_pos - 1'b1;
`endif
            end
            if (d == 4'd0 || d == 4'd1 || d == 4'd15) m_prev = b;
            else begin m_fault = 1'b1; m_state = M_FAULT; end
          end
        end else begin
          if (clr_fault) begin m_fault = 1'b0; m_state = M_SEED; end
        end
        if (push) begin
          if (sz == DEPTH && !pop) begin
            if (m_drop != 8'hFF) m_drop = m_drop + 1'b1;
          end else sb.push_back({dir, m_pos});
        end
      end
    end
  end

  // Apply one cycle of stimulus; returns just after the sampling edge.
  task automatic cyc(input logic v, input logic [3:0] g, input logic rdy, input logic clr);
    gray_valid = v; gray_in = g; out_ready = rdy; clr_fault = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".pos"}, 32'(pos), 32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_data"}, 32'(out_data), 32'd0);
    check({tag, ".out_dir"}, 32'(out_dir), 32'd0);
    check({tag, ".fault"}, 32'(fault), 32'd0);
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  int base;

  initial begin
    // Power-up reset; model tracking begins once one reset edge has passed.
    rst_n = 1'b0;
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    check_reset_outputs("reset");

    // Seed then three up steps, consumer always ready.
    base = n_pop;
    cyc(1'b1, 4'b0000, 1'b1, 1'b0);
    check("seed.no_event", 32'(out_valid), 32'd0);
    cyc(1'b1, 4'b0001, 1'b1, 1'b0);
    cyc(1'b1, 4'b0011, 1'b1, 1'b0);
    cyc(1'b1, 4'b0010, 1'b1, 1'b0);
    check("up.pos", 32'(pos), 32'd3);
    cyc(1'b0, 4'b0010, 1'b1, 1'b0);
    check("up.pops", 32'(n_pop - base), 32'd3);
    check("up.fault", 32'(fault), 32'd0);
    cyc(1'b1, 4'b0010, 1'b1, 1'b1);   // repeat code plus stray clr_fault

    // Down steps through zero.
    do_reset();
    cyc(1'b1, 4'b0011, 1'b1, 1'b0);
    cyc(1'b1, 4'b0001, 1'b1, 1'b0);
`ifdef POS_SAT_EN
    check("down1.pos", 32'(pos), 32'h0000);
`else
    check("down1.pos", 32'(pos), 32'hFFFF);
`endif
    cyc(1'b1, 4'b0000, 1'b1, 1'b0);
`ifdef POS_SAT_EN
    check("down2.pos", 32'(pos), 32'h0000);
`else
    check("down2.pos", 32'(pos), 32'hFFFE);
`endif

    // Illegal jump from bin 2 to bin 5, ignored samples, clear and reseed.
    cyc(1'b1, 4'b0001, 1'b1, 1'b0);
    cyc(1'b1, 4'b0011, 1'b1, 1'b0);
    cyc(1'b1, 4'b0111, 1'b1, 1'b0);
    check("jump.fault", 32'(fault), 32'd1);
    cyc(1'b1, 4'b0110, 1'b1, 1'b0);
    check("jump.ignored_valid", 32'(out_valid), 32'd0);
    cyc(1'b1, 4'b0101, 1'b1, 1'b1);   // clear together with a sample
    check("clr.fault", 32'(fault), 32'd0);
    cyc(1'b1, 4'b0100, 1'b1, 1'b0);   // reseed at bin 7, no event
    check("reseed.no_event", 32'(out_valid), 32'd0);
    cyc(1'b1, 4'b1100, 1'b1, 1'b0);   // bin 8: up
`ifdef POS_SAT_EN
    check("reseed.pos", 32'(pos), 32'd3);
`else
    check("reseed.pos", 32'(pos), 32'd1);
`endif
    cyc(1'b0, 4'b1100, 1'b1, 1'b0);

    // Overfill the FIFO with the consumer stalled.
    do_reset();
    cyc(1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b0, 1'b0);
    cyc(1'b1, 4'b0011, 1'b0, 1'b0);
    cyc(1'b1, 4'b0010, 1'b0, 1'b0);
    cyc(1'b1, 4'b0110, 1'b0, 1'b0);
    cyc(1'b1, 4'b0111, 1'b0, 1'b0);
    cyc(1'b1, 4'b0101, 1'b0, 1'b0);
    check("full.drop_cnt", 32'(drop_cnt), 32'd2);
    check("full.pos", 32'(pos), 32'd6);
    check("full.out_valid", 32'(out_valid), 32'd1);
    check("full.head", 32'(out_data), 32'd1);
    cyc(1'b0, 4'b0101, 1'b0, 1'b0);
    check("stall.head_stable", 32'(out_data), 32'd1);
    base = n_pop;
    cyc(1'b1, 4'b0100, 1'b1, 1'b0);   // push and pop while full
    check("fullpp.drop_cnt", 32'(drop_cnt), 32'd2);
    repeat (6) cyc(1'b0, 4'b0100, 1'b1, 1'b0);
    check("drain.pops", 32'(n_pop - base), 32'd5);

    // Reset with entries queued and fault set.
    do_reset();
    cyc(1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 4'b0001, 1'b0, 1'b0);
    cyc(1'b1, 4'b0011, 1'b0, 1'b0);
    cyc(1'b1, 4'b0010, 1'b0, 1'b0);
    cyc(1'b1, 4'b1010, 1'b0, 1'b0);
    check("pre_rst.fault", 32'(fault), 32'd1);
    do_reset();
    check_reset_outputs("midrst");
    cyc(1'b1, 4'b0010, 1'b1, 1'b0);   // must reseed, not compare to old bin
    check("midrst.seed", 32'(out_valid), 32'd0);
    cyc(1'b1, 4'b0110, 1'b1, 1'b0);
    check("midrst.step", 32'(pos), 32'd1);
    repeat (2) cyc(1'b0, 4'b0110, 1'b1, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
